// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-field bus between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int OP_W   = 5,
  parameter int REG_AW = 4
);
  logic [OP_W-1:0]   idOpCode;
  logic [REG_AW-1:0] idRsAddr;
  logic [REG_AW-1:0] idRtAddr;
  logic              idUsesRt;
  logic              exValid;
  logic [OP_W-1:0]   exOpCode;
  logic [REG_AW-1:0] exRdAddr;
  logic              branchTaken;
  logic              pcEn;
  logic              ifidEn;
  logic              ifidFlush;
  logic              idexEn;
  logic              idexFlush;
  logic              exmemFlush;
  logic              exBusy;

  modport master (
    output idOpCode, idRsAddr, idRtAddr, idUsesRt, exValid, exOpCode, exRdAddr, branchTaken,
    input  pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemFlush, exBusy
  );

  modport slave (
    input  idOpCode, idRsAddr, idRtAddr, idUsesRt, exValid, exOpCode, exRdAddr, branchTaken,
    output pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemFlush, exBusy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, taken-branch flush and multicycle-EX hold control for the 5-stage pipeline.
// Optional HAZARD_PERF_EN adds stallCycles/flushCount performance counters.
module pipeline_hazard_ctrl #(
  parameter int              OP_W      = 5,
  parameter int              REG_AW    = 4,
  parameter logic [OP_W-1:0] OP_LOAD   = OP_W'(3),
  parameter logic [OP_W-1:0] OP_MULTI  = OP_W'(11),
  parameter int unsigned     MC_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           stallCycles,
  output logic [31:0]           flushCount
`endif
);

  localparam int unsigned     CNT_W    = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MC_CYCLES > 1) ? MC_CYCLES - 2 : 0);

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mc_hit, lu_hit, rs_match, rt_match;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, ex_busy;

  // No hazard rule depends on the ID opcode; it rides the bus for the datapath's benefit.
  logic unused_id_opcode;
  assign unused_id_opcode = ^hz.idOpCode;

  assign mc_hit   = hz.exValid && (hz.exOpCode == OP_MULTI);
  assign rs_match = (hz.exRdAddr == hz.idRsAddr);
  assign rt_match = hz.idUsesRt && (hz.exRdAddr == hz.idRtAddr);
  assign lu_hit   = hz.exValid && (hz.exOpCode == OP_LOAD) && (hz.exRdAddr != '0)
                    && (rs_match || rt_match);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    ex_busy     = 1'b0;
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (hz.branchTaken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (mc_hit && (MC_CYCLES > 1)) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            ex_busy     = 1'b1;
            state_d     = MC_BUSY;
            cnt_d       = CNT_INIT;
          end else if (lu_hit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MC_BUSY: begin
          // cnt==0 is the release cycle: EX finishes, the pipeline advances again.
          ex_busy = 1'b1;
          if (cnt_q != '0) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            cnt_d       = cnt_q - CNT_W'(1);
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.pcEn       = pc_en;
  assign hz.ifidEn     = ifid_en;
  assign hz.ifidFlush  = ifid_flush;
  assign hz.idexEn     = idex_en;
  assign hz.idexFlush  = idex_flush;
  assign hz.exmemFlush = exmem_flush;
  assign hz.exBusy     = ex_busy;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!pc_en)     stall_cycles_q <= stall_cycles_q + 32'd1;
      if (ifid_flush) flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign stallCycles = stall_cycles_q;
  assign flushCount  = flush_count_q;
`endif

endmodule
